spi_ram_arbiter: RTL
====================

# spi_ram_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip RAM between the Nios II data master (m0) and the SPI DMA/bridge master (m1). It sits between the two Avalon-MM masters and the RAM's s1 slave port. It serialises accesses, returns read data with fixed latency to the owning master, and blocks out-of-range addresses. One transaction is granted per cycle; the loser is stalled with waitrequest.

## Interface
Parameters:
- ADDR_W, 14, word address width of both masters and the RAM
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 10240, number of implemented RAM words; addresses >= DEPTH are out of range
- ERR_DATA, 32'hDEADBEEF, read data returned for out-of-range reads

Ports:
- clk  in  1  single clock for the block and the RAM
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  master word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- ram_address  out  ADDR_W  to RAM address
- ram_chipselect  out  1  RAM access strobe
- ram_write  out  1  RAM write
- ram_writedata  out  DATA_W  RAM write data
- ram_byteenable  out  DATA_W/8  RAM byte enables
- ram_clken  out  1  RAM clock enable, tied 1
- ram_readdata  in  DATA_W  RAM q (unregistered output, valid 1 cycle after address)
- oor_error  out  1  sticky: an out-of-range access occurred
- oor_clear  in  1  clears oor_error

## Operation
- A master requests when read or write is high. If read and write are both high, the access is treated as a write and the read is ignored.
- Grant is combinational each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master not recorded in the last_grant register wins.
  - last_grant updates on every grant.
  - Reset value of last_grant is 1, so m0 wins the first tie.
- Granted master sees waitrequest=0. Any other requesting master sees waitrequest=1 and holds its request. A non-requesting master sees waitrequest=1.
- RAM-side signals (address, writedata, byteenable) carry the granted master's values in the same cycle.
  - ram_chipselect is 1 only for a granted in-range access.
  - ram_write=1 for a granted in-range write.
- Read grant sets the pipeline register rd_pend (valid, owner, oor).
  - Next cycle: owner's readdatavalid=1.
  - readdata = ram_readdata, or ERR_DATA if oor.
  - Non-owner readdatavalid=0. readdata for a non-owner, or when not valid, is don't-care; drive 0.
- Out-of-range (address >= DEPTH):
  - Never forwarded to the RAM (ram_chipselect=0).
  - Writes are accepted and dropped.
  - Reads complete normally with ERR_DATA.
  - oor_error is set.
- oor_error: set has priority over oor_clear in the same cycle.
- Reset mid-operation: a pending read is discarded and no readdatavalid is issued. All state clears asynchronously.

## Timing
- Reset values:
  - last_grant=1, rd_pend.valid=0, oor_error=0.
  - Both waitrequest=1, both readdatavalid=0, both readdata=0.
  - ram_chipselect=0, ram_write=0, ram_clken=1.
- Write latency: accepted on the cycle waitrequest=0; RAM written at that clock edge.
- Read latency: readdatavalid exactly 1 cycle after acceptance. Fully pipelined: back-to-back reads from one master give 1 read per cycle.
- Contention: with both masters continuously requesting, grants strictly alternate m0, m1, m0, …. A master waits at most 1 cycle.
- Read-after-write to the same address by either master in consecutive cycles returns the new data: the write is committed at the edge before the read address is registered.

## Test plan
- After reset, m0 writes 32'h12345678 to address 5 with byteenable 4'hF, then reads address 5 -> m0_waitrequest=0 on both; m0_readdatavalid 1 cycle after the read with 32'h12345678.
- m0 and m1 both read continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1. Each readdatavalid pulses only on its own master, 1 cycle after its grant.
- m1 writes 32'hAABBCCDD to address 7 with byteenable 4'b0101 over prior 0 -> subsequent read returns 32'h00BB00DD.
- m0 reads address 10240 -> ram_chipselect=0, m0_readdata=32'hDEADBEEF with valid next cycle, oor_error=1. oor_clear pulse -> oor_error=0.
- m0 issues a read and reset is asserted on the following cycle -> no readdatavalid. After release, first tie is won by m0.
- m1 writes address 3 while m0 simultaneously requests a read of address 3 -> if m1 is granted first, m0 reads the new value 1 cycle later.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sharing of one single-port RAM between
// two Avalon-MM masters, with fixed-latency reads and range blocking.
module spi_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH = 10240,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                oor_error,
  input  logic                oor_clear
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } rd_pend_t;

  logic          req0;
  logic          req1;
  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic          last_grant;
  logic          sel_wr;
  logic          sel_oor;
  logic [DATA_W-1:0] rd_data;
  rd_pend_t      rd_pend;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // m1 wins alone, or on a tie when m0 was granted last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt1 = req1 & (~req0 | ~last_grant);
      gnt0 = req0 & ~gnt1;
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  always_comb begin
    ram_address    = m0_address;
    ram_writedata  = m0_writedata;
    ram_byteenable = m0_byteenable;
    sel_wr         = m0_write;
    unique case (1'b1)
      gnt1: begin
        ram_address    = m1_address;
        ram_writedata  = m1_writedata;
        ram_byteenable = m1_byteenable;
        sel_wr         = m1_write;
      end
      default: ;
    endcase
  end

  assign sel_oor        = {1'b0, ram_address} >= LIMIT;
  assign ram_chipselect = gnt_any & ~sel_oor;
  assign ram_write      = ram_chipselect & sel_wr;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend    <= '0;
      last_grant <= 1'b1;
      oor_error  <= 1'b0;
    end else begin
      rd_pend.valid <= gnt_any & ~sel_wr;
      rd_pend.owner <= gnt1;
      rd_pend.oor   <= sel_oor;
      if (gnt_any)
        last_grant <= gnt1;
      if (gnt_any & sel_oor)
        oor_error <= 1'b1;
      else if (oor_clear)
        oor_error <= 1'b0;
    end
  end

  assign rd_data = rd_pend.oor ? ERR_DATA : ram_readdata;

  assign m0_readdatavalid = rd_pend.valid & ~rd_pend.owner;
  assign m1_readdatavalid = rd_pend.valid & rd_pend.owner;
  assign m0_readdata = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata = m1_readdatavalid ? rd_data : '0;

endmodule
